// File: rtl/spi_slave_frontend.sv
// SPI slave front end for the single-port SPI RAM.
// Deserialises MOSI frames to rx_data and serialises RAM read data on MISO.
module spi_slave_frontend #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [MEM_WIDTH+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 frame_err
);

  localparam int FW = MEM_WIDTH + 2;
  localparam int CB = $clog2(FW);
  localparam int CW = (CB < 4) ? 4 : CB;

  if (MEM_DEPTH > 0) begin : g_depth_ok
  end

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SHIFT_OUT,
    HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FW-2:0]       sr_q, sr_d;
  logic [MEM_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic                rd_addr_q, rd_addr_d;
  logic [FW-1:0]       rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                miso_q, miso_d;

  logic [FW-1:0] frame;
  logic [1:0]    ctrl;
  logic          last_bit;
  logic          abort;
  logic          frame_ok;

  assign frame    = {sr_q, MOSI};
  assign ctrl     = frame[FW-1 -: 2];
  assign last_bit = (cnt_q == CW'(FW - 1));
  assign abort    = (state_q != IDLE) && SS_n;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (!SS_n) state_d = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)          state_d = WRITE;
          else if (rd_addr_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        WRITE,
        READ_ADD:  if (last_bit) state_d = HOLD;
        READ_DATA: if (last_bit) state_d = (ctrl == 2'b11) ? WAIT_TX : HOLD;
        WAIT_TX:   if (tx_valid) state_d = SHIFT_OUT;
        SHIFT_OUT: if (cnt_q == CW'(MEM_WIDTH)) state_d = HOLD;
        HOLD:      state_d = HOLD;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok = 1'b0;
    unique case (state_q)
      WRITE:     frame_ok = (ctrl[1] == 1'b0);
      READ_ADD:  frame_ok = (ctrl == 2'b10);
      READ_DATA: frame_ok = (ctrl == 2'b11);
      default:   frame_ok = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    tx_sr_d     = tx_sr_q;
    rd_addr_d   = rd_addr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = 1'b0;
    if (abort) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: cnt_d = '0;
        CHK_CMD: begin
          sr_d  = {sr_q[FW-3:0], MOSI};
          cnt_d = CW'(1);
        end
        WRITE, READ_ADD, READ_DATA: begin
          sr_d  = {sr_q[FW-3:0], MOSI};
          cnt_d = cnt_q + CW'(1);
          if (last_bit) begin
            cnt_d = '0;
            if (frame_ok) begin
              rx_data_d  = frame;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_d = 1'b0;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            tx_sr_d = {tx_data[MEM_WIDTH-2:0], 1'b0};
            miso_d  = tx_data[MEM_WIDTH-1];
            cnt_d   = CW'(1);
          end
        end
        SHIFT_OUT: begin
          if (cnt_q == CW'(MEM_WIDTH)) begin
            cnt_d = '0;
          end else begin
            miso_d  = tx_sr_q[MEM_WIDTH-1];
            tx_sr_d = {tx_sr_q[MEM_WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end
        end
        HOLD:    cnt_d = '0;
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      tx_sr_q     <= '0;
      rd_addr_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      tx_sr_q     <= tx_sr_d;
      rd_addr_q   <= rd_addr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
